// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding and PC width for the fetch controller
package fetch_ctrl_pkg;
  localparam int PC_W = 8;
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, FLUSH, DONE} fetch_ctrl_state_t;
endpackage

// File: rtl/fetch_ctrl_sat.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (reset || clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: launches programs and steers fetch_unit on branches, halts, stalls and watchdog
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int            CW         = 16,
  parameter logic [CW-1:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            instr_valid,
  input  logic            stall,
  input  logic            is_branch,
  input  logic            br_cond,
  input  logic [PC_W-1:0] br_target,
  input  logic            is_halt,
  output logic            fetch_start,
  output logic [PC_W-1:0] fetch_start_addr,
  output logic            fetch_branch,
  output logic            fetch_taken,
  output logic [PC_W-1:0] fetch_target,
  output logic            squash,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [CW-1:0]   instr_count,
  output logic [CW-1:0]   cycle_count
);
  fetch_ctrl_state_t state, next;
  logic [PC_W-1:0] addr_q;
  logic run_like, wd, ev, retire, hold;
  assign run_like = state == RUN || state == FLUSH;
  assign wd       = run_like && cycle_count == MAX_CYCLES;
  assign ev       = instr_valid && !stall;
  assign squash   = state == FLUSH;
  assign busy     = state == LAUNCH || run_like;
  assign done     = state == DONE;
  always_ff @(posedge clk)
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= next;
      addr_q  <= (state == IDLE && start) ? start_addr : addr_q;
      timeout <= next == IDLE ? 1'b0 : timeout | wd;
    end
  // hold freezes the fetch unit by re-targeting the address already in flight
  always_comb begin
    next             = state;
    hold             = 1'b0;
    retire           = 1'b0;
    fetch_start      = 1'b0;
    fetch_start_addr = '0;
    fetch_branch     = 1'b0;
    fetch_taken      = 1'b0;
    fetch_target     = '0;
    case (state)
      IDLE: next = start ? LAUNCH : IDLE;
      LAUNCH: begin
        fetch_start      = 1'b1;
        fetch_start_addr = addr_q;
        next             = RUN;
      end
      RUN:
        if (wd) begin
          hold = 1'b1;
          next = DONE;
        end else if (stall) hold = 1'b1;
        else if (ev && is_halt) begin
          hold   = 1'b1;
          retire = 1'b1;
          next   = DONE;
        end else if (ev && is_branch) begin
          fetch_branch = 1'b1;
          retire       = 1'b1;
          fetch_taken  = br_cond;
          fetch_target = br_cond ? br_target : '0;
          next         = br_cond ? FLUSH : RUN;
        end else retire = ev;
      FLUSH: begin
        hold = wd || stall;
        next = wd ? DONE : stall ? FLUSH : RUN;
      end
      DONE: begin
        hold = 1'b1;
        next = start ? DONE : IDLE;
      end
      default: next = IDLE;
    endcase
    if (hold) begin
      fetch_taken  = 1'b1;
      fetch_target = pc_cur;
    end
  end
  sat_counter #(.W(CW)) u_instr (
    .clk(clk), .reset(reset), .clr(next == IDLE), .inc(retire), .q(instr_count)
  );
  sat_counter #(.W(CW)) u_cycle (
    .clk(clk), .reset(reset), .clr(next == IDLE), .inc(run_like && !wd), .q(cycle_count)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed plan plus random traffic against a cycle-level reference model
module tb_fetch_ctrl;
  localparam int MAXC = 20;
  localparam int M_IDLE = 0, M_LAUNCH = 1, M_RUN = 2, M_FLUSH = 3, M_DONE = 4;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] start_addr = 0, pc = 0, br_target = 0;
  logic instr_valid = 0, stall = 0, is_branch = 0, br_cond = 0, is_halt = 0;
  logic fetch_start, fetch_branch, fetch_taken, squash, busy, done, timeout;
  logic [7:0] fetch_start_addr, fetch_target;
  logic [15:0] instr_count, cycle_count;
  int tests = 0, fails = 0;
  int m_mode = M_IDLE, m_ic = 0, m_cc = 0, m_addr = 0;
  bit m_to = 0;
  fetch_ctrl #(.CW(16), .MAX_CYCLES(16'd20)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .pc_cur(pc),
    .instr_valid(instr_valid), .stall(stall), .is_branch(is_branch), .br_cond(br_cond),
    .br_target(br_target), .is_halt(is_halt), .fetch_start(fetch_start),
    .fetch_start_addr(fetch_start_addr), .fetch_branch(fetch_branch), .fetch_taken(fetch_taken),
    .fetch_target(fetch_target), .squash(squash), .busy(busy), .done(done), .timeout(timeout),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_in(bit iv, bit st, bit br, bit cd, logic [7:0] tg, bit ht);
    instr_valid = iv; stall = st; is_branch = br; br_cond = cd; br_target = tg; is_halt = ht;
  endtask
  // one clock: compare every output with the model, then advance model and fetch-unit PC
  task automatic cyc();
    bit active, wd, ev, hold, e_br, e_tk, e_st;
    int e_tg, n_mode, n_ic, n_cc, n_addr;
    bit n_to;
    @(negedge clk);
    active = m_mode == M_RUN || m_mode == M_FLUSH;
    wd = active && m_cc == MAXC;
    ev = instr_valid && !stall;
    e_st = m_mode == M_LAUNCH;
    hold = m_mode == M_DONE || wd || (active && stall) || (m_mode == M_RUN && ev && is_halt);
    e_br = m_mode == M_RUN && !wd && ev && !is_halt && is_branch;
    e_tk = hold || (e_br && br_cond);
    e_tg = hold ? pc : e_tk ? br_target : 0;
    check("fetch_start", fetch_start, e_st);
    check("fetch_start_addr", fetch_start_addr, e_st ? m_addr : 0);
    check("fetch_branch", fetch_branch, e_br);
    check("fetch_taken", fetch_taken, e_tk);
    check("fetch_target", fetch_target, e_tg);
    check("squash", squash, m_mode == M_FLUSH);
    check("busy", busy, m_mode == M_LAUNCH || active);
    check("done", done, m_mode == M_DONE);
    check("timeout", timeout, m_to);
    check("instr_count", instr_count, m_ic);
    check("cycle_count", cycle_count, m_cc);
    n_mode = m_mode; n_ic = m_ic; n_cc = m_cc; n_addr = m_addr; n_to = m_to;
    if (m_mode == M_IDLE && start) begin
      n_mode = M_LAUNCH; n_addr = start_addr;
    end else if (m_mode == M_LAUNCH) n_mode = M_RUN;
    else if (wd) begin
      n_to = 1; n_mode = M_DONE;
    end else if (active) begin
      n_cc = m_cc < 65535 ? m_cc + 1 : m_cc;
      if (m_mode == M_FLUSH) n_mode = stall ? M_FLUSH : M_RUN;
      else if (ev) begin
        n_ic = m_ic < 65535 ? m_ic + 1 : m_ic;
        n_mode = is_halt ? M_DONE : (is_branch && br_cond) ? M_FLUSH : M_RUN;
      end
    end else if (m_mode == M_DONE && !start) n_mode = M_IDLE;
    if (reset) begin
      n_mode = M_IDLE; n_addr = 0;
    end
    if (n_mode == M_IDLE) begin
      n_ic = 0; n_cc = 0; n_to = 0;
    end
    @(posedge clk);
    #1;
    pc = e_tk ? e_tg[7:0] : e_st ? m_addr[7:0] : pc + 8'd1;
    m_mode = n_mode; m_ic = n_ic; m_cc = n_cc; m_addr = n_addr; m_to = n_to;
  endtask
  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    reset = 0;
    cyc();
    start = 1; start_addr = 8'h10;
    cyc();
    cyc();
    set_in(1, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    check("launch_ic", instr_count, 3);
    check("launch_pc", pc, 8'h13);
    set_in(1, 0, 1, 1, 8'h40, 0);
    cyc();
    check("br_squash", squash, 1);
    set_in(1, 0, 0, 0, 0, 0);
    cyc();
    check("flush_no_retire", instr_count, 4);
    cyc();
    set_in(1, 0, 1, 0, 8'h77, 0);
    cyc();
    check("nt_no_flush", squash, 0);
    check("nt_ic", instr_count, 6);
    set_in(1, 1, 0, 0, 0, 0);
    repeat (3) cyc();
    check("stall_ic", instr_count, 6);
    check("stall_cc", cycle_count, 10);
    set_in(1, 0, 0, 0, 0, 1);
    cyc();
    check("halt_done", done, 1);
    check("halt_ic", instr_count, 7);
    set_in(1, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    check("done_sticky", done, 1);
    start = 0;
    cyc();
    check("idle_done", done, 0);
    check("idle_ic", instr_count, 0);
    start = 1; start_addr = 8'h00;
    repeat (2) cyc();
    repeat (25) cyc();
    check("wd_timeout", timeout, 1);
    check("wd_done", done, 1);
    check("wd_cc", cycle_count, MAXC);
    start = 0;
    cyc();
    check("wd_clear", timeout, 0);
    start = 1; start_addr = 8'h30;
    repeat (2) cyc();
    set_in(1, 0, 1, 1, 8'h80, 0);
    cyc();
    check("pre_rst_flush", squash, 1);
    reset = 1;
    cyc();
    reset = 0;
    check("rst_busy", busy, 0);
    check("rst_squash", squash, 0);
    check("rst_ic", instr_count, 0);
    repeat (3000) begin
      reset = $urandom_range(63) == 0;
      start = $urandom_range(3) != 0;
      start_addr = 8'($urandom);
      set_in($urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
             $urandom_range(1) == 1, 8'($urandom), $urandom_range(15) == 0);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
